// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: word-organised data memory, byte/half/word access, sticky fault record
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        FaultClr,
    output logic [31:0] ReadDataM,
    output logic        FaultM,
    output logic        FaultValid,
    output logic [31:0] FaultAddr,
    output logic [7:0]  FaultCount
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic          r_fault_valid;
    logic [31:0]   r_fault_addr;
    logic [7:0]    r_fault_count;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_legal_load;
    logic          w_legal_store;
    logic          w_illegal;
    logic          w_misaligned;
    logic          w_fault;
    logic          w_store_en;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Upper address bits are dropped, so accesses wrap modulo 4*DEPTH
    assign w_idx    = ALUResultM[AW+1:2];
    assign w_off    = ALUResultM[1:0];
    assign w_unused = ^ALUResultM[31:AW+2];
    assign w_word   = r_mem[w_idx];

    always_comb begin
        w_legal_load  = Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        w_legal_store = Funct3M inside {3'b000, 3'b001, 3'b010};
        w_illegal     = (MemReadM & ~w_legal_load) | (MemWriteM & ~w_legal_store);
        w_misaligned  = ((Funct3M[1:0] == 2'b01) & w_off[0]) |
                        ((Funct3M[1:0] == 2'b10) & (w_off != 2'b00));
        w_fault       = (MemReadM | MemWriteM) &
                        (w_illegal | w_misaligned | (MemReadM & MemWriteM));
        w_store_en    = MemWriteM & ~w_fault;
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        case (w_off)
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half  = w_off[1] ? w_word[31:16] : w_word[15:0];
        w_rdata = 32'h0;
        if (MemReadM && !w_fault) begin
            case (Funct3M[1:0])
                2'b00:   w_rdata = Funct3M[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                2'b01:   w_rdata = Funct3M[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                2'b10:   w_rdata = w_word;
                default: w_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
            r_fault_valid <= 1'b0;
            r_fault_addr  <= 32'h0;
            r_fault_count <= 8'h0;
        end else begin
            if (w_store_en) begin
                for (int l = 0; l < 4; l++)
                    if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
            end
            // A fault in the clear cycle restarts the record from this access
            if (w_fault && FaultClr) begin
                r_fault_valid <= 1'b1;
                r_fault_addr  <= ALUResultM;
                r_fault_count <= 8'd1;
            end else if (w_fault) begin
                if (!r_fault_valid) r_fault_addr <= ALUResultM;
                r_fault_valid <= 1'b1;
                if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
            end else if (FaultClr) begin
                r_fault_valid <= 1'b0;
                r_fault_count <= 8'h0;
            end
        end
    end

    assign ReadDataM  = w_rdata;
    assign FaultM     = w_fault;
    assign FaultValid = r_fault_valid;
    assign FaultAddr  = r_fault_addr;
    assign FaultCount = r_fault_count;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemReadM, FaultClr;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM, FaultAddr;
    logic        FaultM, FaultValid;
    logic [7:0]  FaultCount;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    localparam int S_RD = 0, S_F = 1, S_FV = 2, S_FA = 3, S_FC = 4;

    mem_stage #(.DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .FaultClr   (FaultClr),
        .ReadDataM  (ReadDataM),
        .FaultM     (FaultM),
        .FaultValid (FaultValid),
        .FaultAddr  (FaultAddr),
        .FaultCount (FaultCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD:    return ReadDataM;
            S_F:     return {31'h0, FaultM};
            S_FV:    return {31'h0, FaultValid};
            S_FA:    return FaultAddr;
            default: return {24'h0, FaultCount};
        endcase
    endfunction

    // Compare everything queued for this cycle mid-cycle, then advance past the edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wdata;
        FaultClr   = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic expect_sticky(input string tag, input logic fv, input logic [31:0] fa, input logic [7:0] fc);
        expect_val({tag, "_fv"}, S_FV, {31'h0, fv});
        expect_val({tag, "_fa"}, S_FA, fa);
        expect_val({tag, "_fc"}, S_FC, {24'h0, fc});
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        idle();
        expect_val("rst_rd", S_RD, 32'h0);
        expect_val("rst_f", S_F, 32'h0);
        expect_sticky("rst", 1'b0, 32'h0, 8'h0);
        step();

        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        expect_val("sw_f", S_F, 32'h0);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        expect_val("lw_rd", S_RD, 32'hDEADBEEF);
        expect_val("lw_f", S_F, 32'h0);
        step();

        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0);
        step();
        drive(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        expect_val("lb_rd", S_RD, 32'hFFFFFF80);
        step();
        drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        expect_val("lbu_rd", S_RD, 32'h00000080);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        expect_val("lw_sb_rd", S_RD, 32'h80000000);
        step();

        drive(1'b0, 1'b1, 3'b001, 32'h22, 32'hFFFF1234, 1'b0);
        step();
        drive(1'b0, 1'b1, 3'b001, 32'h20, 32'h0000ABCD, 1'b0);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        expect_val("lw_sh_rd", S_RD, 32'h1234ABCD);
        step();
        drive(1'b1, 1'b0, 3'b001, 32'h20, 32'h0, 1'b0);
        expect_val("lh_rd", S_RD, 32'hFFFFABCD);
        step();
        drive(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
        expect_val("lhu_rd", S_RD, 32'h00001234);
        step();

        drive(1'b0, 1'b1, 3'b010, 32'h11, 32'h55555555, 1'b0);
        expect_val("missw_f", S_F, 32'h1);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        expect_val("missw_mem", S_RD, 32'h80000000);
        expect_val("missw_lwf", S_F, 32'h0);
        expect_sticky("missw", 1'b1, 32'h11, 8'd1);
        step();

        drive(1'b1, 1'b0, 3'b110, 32'h10, 32'h0, 1'b0);
        expect_val("ill_f", S_F, 32'h1);
        expect_val("ill_rd", S_RD, 32'h0);
        step();
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0);
        expect_val("rw_f", S_F, 32'h1);
        step();
        drive(1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 1'b0);
        expect_val("illst_f", S_F, 32'h1);
        step();
        drive(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 1'b0);
        expect_val("mislh_f", S_F, 32'h1);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        expect_val("illst_mem", S_RD, 32'h80000000);
        expect_sticky("multi", 1'b1, 32'h11, 8'd5);
        step();

        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        step();
        idle();
        expect_sticky("clr", 1'b0, 32'h11, 8'd0);
        step();

        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 1'b0);
            if (i < 4 || i == 299) expect_val("sat_f", S_F, 32'h1);
            step();
        end
        idle();
        expect_sticky("sat", 1'b1, 32'h02, 8'd255);
        step();
        drive(1'b1, 1'b0, 3'b001, 32'h05, 32'h0, 1'b1);
        expect_val("race_f", S_F, 32'h1);
        step();
        idle();
        expect_sticky("race", 1'b1, 32'h05, 8'd1);
        step();

        drive(1'b0, 1'b1, 3'b010, 32'h400, 32'h77, 1'b0);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        expect_val("wrap_rd", S_RD, 32'h77);
        step();

        reset = 1'b1;
        drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h99, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        expect_val("rst2_rd", S_RD, 32'h0);
        expect_sticky("rst2", 1'b0, 32'h0, 8'd0);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        expect_val("rst2_rd20", S_RD, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage RISC-V pipeline, between the EX/MEM and MEM/WB pipeline registers. Holds the word-organised data memory. Performs RV32I byte, halfword and word loads and stores, and detects misaligned or illegal accesses. Produces `ReadDataM` for the MEM/WB register and keeps a sticky fault record for debug.

## Interface
- `DEPTH`, default 256: data memory size in 32-bit words; must be a power of two ≥ 4. `AW = log2(DEPTH)`.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemWriteM`  in  1  store request this cycle.
- `MemReadM`  in  1  load request this cycle.
- `Funct3M`  in  3  RV32I load/store width/sign code.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store data, right-aligned.
- `FaultClr`  in  1  clears sticky fault state.
- `ReadDataM`  out  32  extended load data (combinational).
- `FaultM`  out  1  current access is faulting (combinational).
- `FaultValid`  out  1  sticky: at least one fault since last clear.
- `FaultAddr`  out  32  address of first fault since last clear.
- `FaultCount`  out  8  saturating fault count.

## Operation
- **Word index:** `ALUResultM[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH`. Byte offset: `off = ALUResultM[1:0]`.
- **Legal load codes:** 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- **Legal store codes:** 000 SB, 001 SH, 010 SW.
- **`FaultM`** = `(MemReadM|MemWriteM)` & any of:
  - illegal code for the requested access;
  - halfword access with `off[0]=1`;
  - word access with `off≠0`;
  - `MemReadM & MemWriteM` both high.
- **Stores:** when `MemWriteM & !FaultM & !reset`, update at the edge.
  - SB writes `WriteDataM[7:0]` to byte lane `off`.
  - SH writes `WriteDataM[15:0]` to lane pair `off[1]`.
  - SW writes the whole word.
  - Other lanes are unchanged.
  - A faulting store writes nothing.
- **Loads:** combinational from the current array contents.
  - Select the lane as for stores.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - `ReadDataM = 0` when `MemReadM=0` or `FaultM=1`.
- **Sticky fault record:**
  - On an edge with `FaultM=1`: if `FaultValid` is 0, capture `FaultAddr ← ALUResultM`. Then set `FaultValid ← 1` and increment `FaultCount`, saturating at 255.
  - `FaultClr` with no fault: `FaultValid ← 0`, `FaultCount ← 0`; `FaultAddr` is held.
  - `FaultClr` and `FaultM` in the same cycle: the fault wins. Result is `FaultValid=1`, `FaultCount=1`, `FaultAddr = ALUResultM`.
- **Reset:** clears every memory word to 0, `FaultValid=0`, `FaultAddr=0`, `FaultCount=0`.
  - Reset overrides any store or fault in the same cycle.
  - With inputs idle after reset, `ReadDataM=0` and `FaultM=0`.

## Timing
- Load latency 0 cycles: `ReadDataM` is valid in the same cycle and is captured by MEM/WB at the next edge.
- Store latency 1 edge: a store at edge N is visible to a load in cycle N+1.
- No read-during-write on one instruction: both requests together is a fault.
- `FaultM` is combinational in the same cycle. Sticky outputs update at the edge after the fault.
- Reset mid-stream: the store in the reset cycle is dropped; memory reads 0 from the next cycle.
- No stall or handshake; the stage accepts one access per cycle, every cycle.

## Test plan
- **Store/load round trip:**
  - Stimulus: reset; SW 0xDEADBEEF to 0x10; next cycle LW 0x10.
  - Required: `ReadDataM=0xDEADBEEF`, `FaultM=0`.
- **Byte store and sign/zero extend** (memory word 0x10 = 0x00000000):
  - Stimulus: SB 0x80 to 0x13; then LB 0x13 and LBU 0x13.
  - Required: LB returns 0xFFFFFF80, LBU returns 0x00000080, LW 0x10 returns 0x80000000.
- **Halfword stores:**
  - Stimulus: SH 0x1234 to 0x22; SH 0xABCD to 0x20.
  - Required: LW 0x20 returns 0x1234ABCD; LH 0x20 returns 0xFFFFABCD.
- **Misaligned store:**
  - Stimulus: SW 0x55555555 to 0x11.
  - Required: `FaultM=1`; memory unchanged (LW 0x10 returns the prior value); next cycle `FaultValid=1`, `FaultAddr=0x11`, `FaultCount=1`.
- **Saturation and clear race:**
  - Stimulus: 300 consecutive LW at 0x02.
  - Required: `FaultCount=255`, `FaultAddr=0x02`.
  - Stimulus: `FaultClr` together with LH 0x05.
  - Required: `FaultCount=1`, `FaultAddr=0x05`.
- **Wrap and reset** (`DEPTH=256`):
  - Stimulus: SW 0x77 to 0x400; LW 0x0.
  - Required: LW 0x0 returns 0x77.
  - Stimulus: assert `reset` with SW active.
  - Required: LW 0x0 returns 0; sticky fault outputs are 0.
